mult_seq: RTL and testbench
===========================

# mult_seq

Iterative 32x32 multiply sequencer for the execute stage. It replaces the single-cycle combinational multiplier and the two-pass cnt/hilo_temp MADD/MSUB scheme with one shift-add engine. The engine takes a start/ready handshake shaped like the divider's and can fold a HI/LO accumulate or subtract into its last step. Execute drives it for MULT, MULTU, MUL, MADD, MADDU, MSUB and MSUBU, and holds its stall request while `ready_o` is low.

## Interface
- `WIDTH`, 32, operand width. The product and accumulator are 2*WIDTH bits wide.
- `clk  input  1`: clock; all state changes on the rising edge.
- `rst  input  1`: asynchronous, active-low reset.
- `start_i  input  1`: request a multiply. Held high by execute until it consumes the result.
- `annul_i  input  1`: abandon the operation in flight (flush or exception).
- `signed_mult_i  input  1`: 1 for a signed (two's-complement) multiply, 0 for unsigned.
- `opdata1_i  input  WIDTH`: multiplicand.
- `opdata2_i  input  WIDTH`: multiplier.
- `acc_i  input  1`: 1 combines the product with `hilo_i`.
- `sub_i  input  1`: with `acc_i` = 1, select `hilo_i - product` (MSUB) instead of `hilo_i + product` (MADD). Ignored when `acc_i` = 0.
- `hilo_i  input  2*WIDTH`: forwarded {HI,LO} value.
- `result_o  output  2*WIDTH`: final value; {HI,LO} for MULT and MADD/MSUB, low half used for MUL.
- `ready_o  output  1`: `result_o` is valid.

## Operation
- State machine states: MulFree, MulOn, MulAcc, MulEnd. Reset state is MulFree, with `result_o` = 0, `ready_o` = 0 and all internal registers = 0.
- **MulFree:**
  - `start_i` = 1 and `annul_i` = 0: latch `signed_mult_i`, `acc_i`, `sub_i`, and the magnitudes of both operands.
    - A magnitude is the two's-complement absolute value when signed and that operand's MSB is 1; otherwise it is the raw operand.
    - Record neg = `signed_mult_i` & (op1 MSB ^ op2 MSB).
  - If either operand is zero: go straight to MulEnd. `result_o` = `hilo_i` if `acc_i` = 1 (whether or not `sub_i` is set), else 0. `ready_o` = 1.
  - Otherwise: clear the product register, load the multiplicand (zero-extended to 2*WIDTH), load the multiplier, clear the iteration counter, and go to MulOn.
  - `start_i` = 1 together with `annul_i` = 1: stay in MulFree.
- **MulOn, one iteration per cycle:**
  - If the multiplier LSB is 1, add the multiplicand to the product.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Increment the counter.
  - After the WIDTH-th iteration (counter reaches WIDTH-1 at that edge), go to MulAcc.
- **MulAcc, single cycle:**
  - Apply the sign: p = neg ? (~product + 1) : product.
  - Sample `hilo_i` in this cycle, not at start, so HI/LO forwarding during the stall is honoured.
  - `result_o` = p, `hilo_i` + p, or `hilo_i` - p per `acc_i`/`sub_i`. All arithmetic is modulo 2^(2*WIDTH) and overflow is ignored.
  - Set `ready_o` = 1 and go to MulEnd.
- **MulEnd:**
  - Hold `result_o` and `ready_o` = 1 while `start_i` = 1.
  - When `start_i` = 0: go to MulFree, set `ready_o` = 0, and reset `result_o` to 0.
- **`annul_i` = 1 in MulOn or MulAcc:** next state is MulFree, `ready_o` stays 0, `result_o` = 0, and the counter clears.
- **`annul_i` in MulEnd:** has no effect; the `start_i` rule applies.
- **Input stability:** operand and mode inputs are don't-care outside the MulFree start edge. `hilo_i` is additionally sampled in MulAcc, or at the start edge on the zero shortcut.
- **Reset asserted at any point:** immediate return to reset values, regardless of state.

## Timing
- Let edge E0 be the first rising edge that samples `start_i` = 1 in MulFree.
- Normal path:
  - Iterations occur at E1 through E32.
  - E32 also enters MulAcc.
  - E33 writes `result_o`, sets `ready_o` = 1 and enters MulEnd.
  - `ready_o` is therefore visible during the cycle after E33: 34 edges of latency.
- Zero-operand path: `ready_o` = 1 is visible the cycle after E0.
- Execute raises its stall while `start_i` = 1 and `ready_o` = 0. It drops `start_i` in the cycle it sees `ready_o` = 1.
- With `start_i` dropped in the cycle `ready_o` = 1 is visible, the following edge returns the block to MulFree. A new start can then be sampled on the edge after that.
- `ready_o` and `result_o` are registered; they have no combinational path from the inputs.

## Test plan
- Unsigned multiply: 0xFFFFFFFF x 0xFFFFFFFF with `signed_mult_i` = 0 and `acc_i` = 0 -> `result_o` = 0xFFFFFFFE00000001, with `ready_o` first high 34 edges after E0.
- Signed multiplies:
  - -3 x 7 -> 0xFFFFFFFFFFFFFFEB.
  - 0x80000000 x 0x80000000 -> 0x4000000000000000.
  - 0x80000000 x 0xFFFFFFFF -> 0x0000000080000000.
- MADD then MSUB: `hilo_i` = 0x0000000100000000, 5 x 6.
  - MADD (`sub_i` = 0) -> 0x000000010000001E.
  - Signed MSUB, -5 x 6 -> 0x000000010000001E.
  - Unsigned MSUB, 2 x 1 with `hilo_i` = 0 -> 0xFFFFFFFFFFFFFFFE.
- Zero shortcut: 0 x 0x1234 with `acc_i` = 1 and `hilo_i` = 0xAB -> `result_o` = 0xAB with `ready_o` high the cycle after E0. Repeat with `sub_i` = 1 -> `result_o` = 0xAB.
- Annul and reset mid-operation:
  - Assert `annul_i` at E10 -> state MulFree, `ready_o` never rises.
  - A new start two cycles later completes correctly.
  - Drive `rst` low during MulOn -> `result_o` = 0 and `ready_o` = 0 immediately, without waiting for a clock edge.
- Handshake hold: keep `start_i` = 1 for 5 cycles after `ready_o` rises -> `result_o` is stable throughout. Dropping `start_i` -> `ready_o` = 0 and `result_o` = 0 on the next edge.

Source files
------------

// File: rtl/mult_seq_if.sv
// Execute-stage <-> multiply sequencer bundle.
// Handshake: the master raises start_i with operands and holds it until it sees
// ready_o; result_o is valid exactly while ready_o is high, and dropping start_i
// releases the sequencer back to idle on the next edge.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic                 signed_mult_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 acc_i;
    logic                 sub_i;
    logic [2*WIDTH-1:0]   hilo_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic [1:0]           dbg_state_o;

    modport master (
        output start_i, annul_i, signed_mult_i, opdata1_i, opdata2_i,
               acc_i, sub_i, hilo_i,
        input  result_o, ready_o, dbg_state_o
    );

    modport slave (
        input  start_i, annul_i, signed_mult_i, opdata1_i, opdata2_i,
               acc_i, sub_i, hilo_i,
        output result_o, ready_o, dbg_state_o
    );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add 32x32 multiplier with optional HI/LO accumulate or
// subtract folded into the final step; one iteration per cycle.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mult_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        MUL_FREE = 2'd0,
        MUL_ON   = 2'd1,
        MUL_ACC  = 2'd2,
        MUL_END  = 2'd3
    } state_t;

    state_t           state;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             acc;
    logic             sub;
    logic [PW-1:0]    result;
    logic             ready;

    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [PW-1:0]    p_signed;
    logic [PW-1:0]    acc_val;

    // The engine works on magnitudes; the sign is reapplied once at the end.
    assign mag1 = (bus.signed_mult_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = (bus.signed_mult_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    assign p_signed = neg ? -prod : prod;
    // hilo_i is read in MUL_ACC so forwarding that lands during the stall is seen.
    assign acc_val  = sub ? (bus.hilo_i - p_signed) : (bus.hilo_i + p_signed);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MUL_FREE;
            prod   <= '0;
            mcand  <= '0;
            mplr   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            acc    <= 1'b0;
            sub    <= 1'b0;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                MUL_FREE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        acc <= bus.acc_i;
                        sub <= bus.sub_i;
                        neg <= bus.signed_mult_i &
                               (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        if (mag1 == '0 || mag2 == '0) begin
                            result <= bus.acc_i ? bus.hilo_i : '0;
                            ready  <= 1'b1;
                            state  <= MUL_END;
                        end else begin
                            prod  <= '0;
                            mcand <= {{WIDTH{1'b0}}, mag1};
                            mplr  <= mag2;
                            cnt   <= '0;
                            state <= MUL_ON;
                        end
                    end
                end
                MUL_ON: begin
                    if (bus.annul_i) begin
                        state  <= MUL_FREE;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        result <= '0;
                    end else begin
                        prod  <= prod + (mplr[0] ? mcand : '0);
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= MUL_ACC;
                    end
                end
                MUL_ACC: begin
                    if (bus.annul_i) begin
                        state  <= MUL_FREE;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        result <= '0;
                    end else begin
                        result <= acc ? acc_val : p_signed;
                        ready  <= 1'b1;
                        state  <= MUL_END;
                    end
                end
                MUL_END: begin
                    if (!bus.start_i) begin
                        state  <= MUL_FREE;
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: state <= MUL_FREE;
            endcase
        end
    end

    assign bus.result_o    = result;
    assign bus.ready_o     = ready;
    assign bus.dbg_state_o = state;
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed vector table, random ops against a
// plain-arithmetic reference, and hand sequences for annul, reset and hold.
module tb_mult_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_seq_if #(.WIDTH(W)) ifc ();
    mult_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic        acc;
        logic        sub;
        logic [63:0] hilo;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sign-extend to 64 bits and multiply modulo 2^64.
    function automatic logic [63:0] ref_model(input logic s, input logic [31:0] a,
                                              input logic [31:0] b, input logic acc,
                                              input logic sub, input logic [63:0] hilo);
        logic [63:0] ae, be, p;
        ae = s ? {{32{a[31]}}, a} : {32'b0, a};
        be = s ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ae * be;
        if (!acc) return p;
        return sub ? hilo - p : hilo + p;
    endfunction

    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic acc, input logic sub, input logic [63:0] hilo);
        @(negedge clk);
        ifc.signed_mult_i = s;
        ifc.opdata1_i     = a;
        ifc.opdata2_i     = b;
        ifc.acc_i         = acc;
        ifc.sub_i         = sub;
        ifc.hilo_i        = hilo;
        ifc.annul_i       = 1'b0;
        ifc.start_i       = 1'b1;
    endtask

    // Counts edges from E0 until ready_o is seen; scrambles operands after E0.
    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                ifc.opdata1_i     = $urandom;
                ifc.opdata2_i     = $urandom;
                ifc.signed_mult_i = 1'($urandom_range(0, 1));
                ifc.acc_i         = 1'($urandom_range(0, 1));
                ifc.sub_i         = 1'($urandom_range(0, 1));
            end
        end while (!ifc.ready_o && lat < 100);
    endtask

    task automatic finish_op(input int hold, input logic [63:0] exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", ifc.result_o, exp);
            check("hold_ready", 64'(ifc.ready_o), 64'd1);
        end
        ifc.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", 64'(ifc.ready_o), 64'd0);
        check("drop_result", ifc.result_o, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] exp;
        logic        s, acc, sub;
        logic [31:0] a, b;
        logic [63:0] hilo;
        logic        rose;

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 64'hFFFFFFFE00000001, 34};
        vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h7, 1'b0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFEB, 34};
        vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 64'h0, 64'h4000000000000000, 34};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 64'h0000000080000000, 34};
        vecs[4] = '{1'b0, 32'd5, 32'd6, 1'b1, 1'b0, 64'h0000000100000000, 64'h000000010000001E, 34};
        vecs[5] = '{1'b1, 32'hFFFFFFFB, 32'd6, 1'b1, 1'b1, 64'h0000000100000000, 64'h000000010000001E, 34};
        vecs[6] = '{1'b0, 32'd2, 32'd1, 1'b1, 1'b1, 64'h0, 64'hFFFFFFFFFFFFFFFE, 34};
        vecs[7] = '{1'b0, 32'h0, 32'h1234, 1'b1, 1'b0, 64'hAB, 64'hAB, 1};
        vecs[8] = '{1'b0, 32'h0, 32'h1234, 1'b1, 1'b1, 64'hAB, 64'hAB, 1};
        vecs[9] = '{1'b1, 32'h7, 32'h0, 1'b0, 1'b0, 64'h55, 64'h0, 1};

        ifc.start_i = 0; ifc.annul_i = 0; ifc.signed_mult_i = 0;
        ifc.opdata1_i = 0; ifc.opdata2_i = 0; ifc.acc_i = 0; ifc.sub_i = 0; ifc.hilo_i = 0;

        // Reset state
        #12;
        check("reset_result", ifc.result_o, 64'd0);
        check("reset_ready", 64'(ifc.ready_o), 64'd0);
        check("reset_state", 64'(ifc.dbg_state_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].sub, vecs[i].hilo);
            wait_ready(lat);
            check($sformatf("vec%0d_result", i), ifc.result_o, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            finish_op(0, vecs[i].exp);
        end

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            s    = 1'($urandom_range(0, 1));
            acc  = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            b    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            hilo = {$urandom, $urandom};
            exp  = ref_model(s, a, b, acc, sub, hilo);
            start_op(s, a, b, acc, sub, hilo);
            wait_ready(lat);
            check("rand_result", ifc.result_o, exp);
            check("rand_latency", 64'(lat), (a == 0 || b == 0) ? 64'd1 : 64'd34);
            finish_op($urandom_range(0, 2), exp);
        end

        // hilo forwarded mid-operation must be the one used
        start_op(1'b0, 32'd3, 32'd4, 1'b1, 1'b0, 64'h1111);
        repeat (6) @(posedge clk);
        @(negedge clk);
        ifc.hilo_i = 64'h0000002200000000;
        wait_ready(lat);
        check("fwd_result", ifc.result_o, 64'h000000220000000C);
        finish_op(0, 64'h0);

        // Annul at E10, then a fresh start two cycles later
        start_op(1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 64'h0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        ifc.annul_i = 1'b1;
        ifc.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul_state", 64'(ifc.dbg_state_o), 64'd0);
        @(negedge clk);
        ifc.annul_i = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ifc.ready_o) rose = 1'b1;
        end
        check("annul_no_ready", 64'(rose), 64'd0);
        start_op(1'b1, 32'hFFFFFFF6, 32'd100, 1'b0, 1'b0, 64'h0);
        wait_ready(lat);
        check("after_annul_result", ifc.result_o, 64'hFFFFFFFFFFFFFC18);
        finish_op(0, 64'h0);

        // Asynchronous reset during MulOn
        start_op(1'b0, 32'd5, 32'd6, 1'b0, 1'b0, 64'h0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_on_state", 64'(ifc.dbg_state_o), 64'd0);
        check("rst_on_ready", 64'(ifc.ready_o), 64'd0);
        ifc.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset while holding a result
        start_op(1'b0, 32'd5, 32'd6, 1'b0, 1'b0, 64'h0);
        wait_ready(lat);
        check("pre_rst_result", ifc.result_o, 64'd30);
        #2;
        rst = 1'b0;
        #1;
        check("rst_end_result", ifc.result_o, 64'd0);
        check("rst_end_ready", 64'(ifc.ready_o), 64'd0);
        ifc.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Handshake hold for 5 cycles, with annul ignored in MulEnd
        start_op(1'b0, 32'h12345678, 32'h10, 1'b0, 1'b0, 64'h0);
        wait_ready(lat);
        check("hold_first", ifc.result_o, 64'h0000000123456780);
        ifc.annul_i = 1'b1;
        finish_op(5, 64'h0000000123456780);
        ifc.annul_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
